// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The loader connects through the slave modport; the byte source and memory side use master.
interface program_loader_if #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
);
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into program memory and
// holds the downstream CPU in reset until a load completes with a valid checksum.
module program_loader #(
  parameter int INSTR_WIDTH = 16,  // multiple of 8, 8..32
  parameter int ADDR_WIDTH  = 8    // 1..16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam int BYTES = INSTR_WIDTH / 8;
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES - 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

  state_t                 state;
  logic [15:0]            len;
  logic [15:0]            word_cnt;
  logic [1:0]             byte_cnt;
  logic [7:0]             csum;
  logic [INSTR_WIDTH-1:0] partial;
  logic [INSTR_WIDTH-1:0] word_next;
  logic [16:0]            len_next;
  logic                   accept;

  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
  assign accept   = bus.in_valid && bus.in_ready;
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign len_next = {1'b0, bus.in_data, len[7:0]};

  // Little-endian insertion of the incoming byte into the word being assembled.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    word_next = partial;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_cnt == 2'(i)) word_next[i*8 +: 8] = bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      len           <= '0;
      word_cnt      <= '0;
      byte_cnt      <= '0;
      csum          <= '0;
      partial       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the default
      // deassertion below turns every write strobe into a one-cycle pulse.
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN_LO;
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            partial  <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.in_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.in_data;
            if (len_next == '0)           state <= CSUM;
            else if (len_next > MAX_WORDS) state <= ERR;
            else                           state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            csum <= csum ^ bus.in_data;
            if (byte_cnt == LAST_BYTE) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              bus.mem_wdata <= word_next;
              byte_cnt      <= '0;
              word_cnt      <= word_cnt + 16'd1;
              if (word_cnt == len - 16'd1) state <= CSUM;
            end else begin
              partial  <= word_next;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        CSUM: begin
          if (accept) state <= (bus.in_data == csum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
